// File: rtl/si_event_frame_tx.sv
`timescale 1ns/1ps
// si_event_frame_tx: packs 64-bit event words into Ethernet frames for a 10G
// MAC TX AXI4-Stream. Each frame has a 2-beat header (MACs, EtherType, 16-bit
// sequence), then up to MAX_WORDS event words. A frame closes when it is full
// or when the input has been idle for TIMEOUT cycles. Frames shorter than six
// payload words are zero-padded so the frame reaches 64 bytes with FCS.
module si_event_frame_tx #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int unsigned MAX_WORDS = 180,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [63:0] s_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic [31:0] frame_count
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MAX_WORDS - 1);
  localparam logic [WC_W-1:0] WC_MIN  = WC_W'(5);
  localparam logic [15:0]     IDLE_MAX = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_PAYLOAD,
    S_PAD
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [63:0]     hold;
  logic            hv;
  logic [WC_W-1:0] wc;
  logic [15:0]     idle_cnt;
  logic [15:0]     seq;
  logic            pend;
  logic            pend_close;
  logic            close_now;
  logic            close_sel;
  logic            offer;
  logic            m_hs;
  logic            s_hs;
  logic            frame_end;

  // Wire order is byte 0 first on tdata[7:0]; headers are written MSB-first
  // and swapped into beat order here.
  function automatic logic [63:0] bswap64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(7-i) +: 8];
    return r;
  endfunction

  // Idle counter increment that sticks at TIMEOUT.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v >= IDLE_MAX) ? IDLE_MAX : v + 16'd1;
  endfunction

  // Payload offer and close decision. Once a beat has been offered and
  // stalled, its close decision is frozen so tvalid/tlast stay stable even
  // if s_axis_tvalid changes while the MAC holds off.
  always_comb begin
    close_now = (wc == WC_LAST) || ((idle_cnt == IDLE_MAX) && !s_axis_tvalid);
    close_sel = pend ? pend_close : close_now;
    offer     = pend || (hv && (s_axis_tvalid || (wc == WC_LAST) || (idle_cnt == IDLE_MAX)));
  end

  // Next-state and AXIS output decode.
  always_comb begin
    state_nxt     = state;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    s_axis_tready = 1'b0;
    case (state)
      S_IDLE: begin
        if (s_axis_tvalid) state_nxt = S_HDR0;
      end
      S_HDR0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = bswap64({DST_MAC, SRC_MAC[47:32]});
        if (m_axis_tready) state_nxt = S_HDR1;
      end
      S_HDR1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = bswap64({SRC_MAC[31:0], ETHERTYPE, seq});
        if (m_axis_tready) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        m_axis_tvalid = offer;
        m_axis_tlast  = close_sel && (wc >= WC_MIN);
        m_axis_tdata  = hold;
        // A closing beat never takes a new word: either the frame ends or
        // the pad beats follow.
        s_axis_tready = !hv || (offer && m_axis_tready && !close_sel);
        if (offer && m_axis_tready && close_sel)
          state_nxt = (wc >= WC_MIN) ? S_IDLE : S_PAD;
      end
      S_PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (wc == WC_MIN);
        if (m_axis_tready && (wc == WC_MIN)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign m_hs         = m_axis_tvalid && m_axis_tready;
  assign s_hs         = s_axis_tvalid && s_axis_tready;
  assign frame_end    = m_hs && m_axis_tlast;
  assign m_axis_tkeep = 8'hFF;

  // Control state: FSM, hold-valid flag, stall latch, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      hv          <= 1'b0;
      pend        <= 1'b0;
      pend_close  <= 1'b0;
      wc          <= '0;
      idle_cnt    <= '0;
      seq         <= '0;
      frame_count <= '0;
    end else begin
      state      <= state_nxt;
      hv         <= (state == S_PAYLOAD) && (s_hs || (hv && !m_hs));
      pend       <= (state == S_PAYLOAD) && offer && !m_axis_tready;
      pend_close <= close_sel;
      if (state == S_IDLE)
        wc <= '0;
      else if (m_hs && ((state == S_PAYLOAD) || (state == S_PAD)))
        wc <= wc + WC_W'(1);
      if ((state != S_PAYLOAD) || s_hs)
        idle_cnt <= '0;
      else if (hv && !s_axis_tvalid)
        idle_cnt <= sat_inc(idle_cnt);
      if (frame_end) begin
        seq         <= seq + 16'd1;
        frame_count <= frame_count + 32'd1;
      end
    end
  end

  // Event word hold register; data only, left out of reset.
  always_ff @(posedge clk) begin
    if (s_hs) hold <= s_axis_tdata;
  end

endmodule

// File: tb/tb_si_event_frame_tx.sv
`timescale 1ns/1ps
// tb_si_event_frame_tx: directed and randomized stimulus; output beats are
// parsed back into frames and checked against the queue of words sent.
module tb_si_event_frame_tx;

  localparam logic [47:0] DST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC  = 48'h02_00_00_00_00_01;
  localparam logic [15:0] ET   = 16'h88B5;
  localparam int          MAXW = 180;
  localparam int          TO   = 16;

  logic        clk;
  logic        rst_n;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic [31:0] frame_count;

  typedef struct {
    logic [63:0] d;
    logic        l;
    int          c;
  } beat_t;

  beat_t       bq[$];
  logic [63:0] sq[$];
  int          flen[$];
  int          flast[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          in_cyc = 0;
  int          exp_seq = 0;
  logic        rnd_ready = 1'b0;

  si_event_frame_tx #(
    .DST_MAC(DST), .SRC_MAC(SRC), .ETHERTYPE(ET), .MAX_WORDS(MAXW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .frame_count(frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Header beat j (0 or 1) built from the wire byte stream DST,SRC,ET,seq.
  function automatic logic [63:0] hdr_beat(input int j, input logic [15:0] s);
    logic [127:0] h;
    logic [63:0]  r;
    h = {DST, SRC, ET, s};
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = h[127 - 8*(8*j + i) -: 8];
    return r;
  endfunction

  // Downstream ready: always 1, or a coin flip each cycle.
  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Beat capture plus stability of stalled beats.
  initial begin : monitor
    logic        pv, pr, pl;
    logic [63:0] pd;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("stall data", m_axis_tdata, pd);
          chk("stall vld_last", {62'd0, m_axis_tvalid, m_axis_tlast}, {62'd0, 1'b1, pl});
        end
        if (m_axis_tvalid && m_axis_tready) bq.push_back('{m_axis_tdata, m_axis_tlast, cyc});
        pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata; pl = m_axis_tlast;
      end
    end
  end

  task automatic send_word(input logic [63:0] w);
    int   k;
    logic got;
    k = 0;
    got = 1'b0;
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    while (!got && k < 4000) begin
      @(negedge clk);
      if (s_axis_tready) got = 1'b1;
      else k++;
    end
    chk("input accepted in time", 64'(got), 64'd1);
    if (got) begin
      in_cyc = cyc;
      sq.push_back(w);
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int k;
    k = 0;
    while (frame_count != 32'(target) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " frame_count"}, 64'(frame_count), 64'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bq.delete();
    sq.delete();
    exp_seq = 0;
    @(posedge clk);
    #1;
  endtask

  // Split captured beats into frames and check each against the sent words.
  task automatic parse_frames(input string tag);
    beat_t b;
    int    n, zeros;
    logic  done;
    logic [63:0] e;
    flen.delete();
    flast.delete();
    while (bq.size() > 0) begin
      b = bq.pop_front();
      chk({tag, " hdr0"}, b.d, hdr_beat(0, 16'(exp_seq)));
      chk({tag, " hdr0 last"}, 64'(b.l), 64'd0);
      chk({tag, " hdr1 present"}, 64'(bq.size() != 0), 64'd1);
      if (bq.size() == 0) break;
      b = bq.pop_front();
      chk({tag, " hdr1"}, b.d, hdr_beat(1, 16'(exp_seq)));
      chk({tag, " hdr1 last"}, 64'(b.l), 64'd0);
      n = 0; zeros = 0; done = 1'b0;
      while (!done && n <= MAXW && bq.size() != 0) begin
        b = bq.pop_front();
        n++;
        if (b.d == 64'd0) begin
          zeros++;
        end else begin
          chk({tag, " data after pad"}, 64'(zeros), 64'd0);
          e = (sq.size() != 0) ? sq.pop_front() : 64'd0;
          chk({tag, " payload"}, b.d, e);
        end
        done = b.l;
      end
      chk({tag, " tlast"}, 64'(done), 64'd1);
      chk({tag, " len<=max"}, 64'(n <= MAXW), 64'd1);
      chk({tag, " len>=6"}, 64'(n >= 6), 64'd1);
      chk({tag, " pad only to 6"}, 64'((zeros == 0) || (n == 6)), 64'd1);
      flen.push_back(n);
      flast.push_back(b.c);
      exp_seq = (exp_seq + 1) % 65536;
    end
    chk({tag, " all words out"}, 64'(sq.size()), 64'd0);
  endtask

  initial begin
    int          base;
    int          t_w3;
    logic [63:0] w;
    rst_n = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'h55;
    m_axis_tready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    // reset state while upstream is already offering data
    chk("rst m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst m_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst m_tdata", m_axis_tdata, 64'd0);
    chk("rst s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst frame_count", 64'(frame_count), 64'd0);
    chk("tkeep", 64'(m_axis_tkeep), 64'hFF);
    s_axis_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // full frame of 180 back-to-back words
    for (int i = 1; i <= 180; i++) send_word(64'(i));
    wait_frames(1, "full");
    parse_frames("full");
    chk("full nframes", 64'(flen.size()), 64'd1);
    chk("full len", 64'(flen[0]), 64'd180);

    // short frame closed by timeout and padded
    for (int i = 1; i <= 3; i++) send_word(64'(i));
    t_w3 = in_cyc;
    wait_frames(2, "short");
    parse_frames("short");
    chk("short nframes", 64'(flen.size()), 64'd1);
    chk("short len", 64'(flen[0]), 64'd6);
    chk("short tlast after timeout", 64'((flast[0] - t_w3) >= TO), 64'd1);

    // input arriving exactly as idle reaches TIMEOUT keeps the frame open
    for (int i = 11; i <= 16; i++) send_word(64'(i));
    repeat (TO) @(posedge clk);
    #1;
    s_axis_tdata = 64'd17;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    chk("race m_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("race m_tlast", 64'(m_axis_tlast), 64'd0);
    chk("race s_tready", 64'(s_axis_tready), 64'd1);
    sq.push_back(64'd17);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    send_word(64'd18);
    wait_frames(3, "race");
    parse_frames("race");
    chk("race nframes", 64'(flen.size()), 64'd1);
    chk("race len", 64'(flen[0]), 64'd8);

    // 400 continuous words after reset: 180 + 180 + 40, seq 0,1,2
    do_reset();
    chk("post-reset frame_count", 64'(frame_count), 64'd0);
    for (int i = 1; i <= 400; i++) send_word(64'(1000 + i));
    wait_frames(3, "split");
    parse_frames("split");
    chk("split nframes", 64'(flen.size()), 64'd3);
    chk("split len0", 64'(flen[0]), 64'd180);
    chk("split len1", 64'(flen[1]), 64'd180);
    chk("split len2", 64'(flen[2]), 64'd40);

    // random gaps and random downstream backpressure
    rnd_ready = 1'b1;
    base = int'(frame_count);
    for (int i = 0; i < 1500; i++) begin
      w = {$urandom(), $urandom()};
      if (w == 64'd0) w = 64'd1;
      send_word(w);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 24)) @(posedge clk);
        #1;
      end
    end
    rnd_ready = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    parse_frames("rand");
    chk("rand frame_count", 64'(frame_count), 64'(base + flen.size()));
    chk("rand frames seen", 64'(flen.size() > 1), 64'd1);

    // reset pulsed while word 50 is being offered
    for (int i = 1; i <= 49; i++) send_word(64'(i));
    s_axis_tdata = 64'd50;
    s_axis_tvalid = 1'b1;
    #1;
    chk("midrst before m_tvalid", 64'(m_axis_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst s_tready", 64'(s_axis_tready), 64'd0);
    chk("midrst m_tdata", m_axis_tdata, 64'd0);
    chk("midrst frame_count", 64'(frame_count), 64'd0);
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bq.delete();
    sq.delete();
    exp_seq = 0;
    @(posedge clk);
    #1;
    for (int i = 5; i <= 7; i++) send_word(64'(i));
    wait_frames(1, "after rst");
    parse_frames("after rst");
    chk("after rst nframes", 64'(flen.size()), 64'd1);
    chk("after rst len", 64'(flen[0]), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
